bcd_seq_converter: RTL

- Multi-cycle, clocked binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one shift per clock.
- Successor to the combinational decoder: trades latency for area on wide inputs.
- Adds a start/busy/done handshake, registered outputs, optional two's-complement input and saturating overflow detection.
- Sits between arithmetic datapaths and the 7-segment display drivers; one BCD digit per display.

---
 rtl/bcd_seq_converter_if.sv | 23 ++
 rtl/bcd_seq_converter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter_if.sv
// Handshake and result bundle between a requester and the sequential BCD converter.
interface bcd_seq_converter_if #(
    parameter int INPUT_LENGTH = 8,
    parameter int N_DISPLAYS   = 3
);
    logic                    start;
    logic [INPUT_LENGTH-1:0] binary_in;
    logic                    busy;
    logic                    done;
    logic [3:0]              out [N_DISPLAYS-1:0];
    logic                    negative;
    logic                    overflow;

    modport master (
        output start, binary_in,
        input  busy, done, out, negative, overflow
    );

    modport slave (
        input  start, binary_in,
        output busy, done, out, negative, overflow
    );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one shift per clock).
// Optional two's-complement input; values beyond N_DISPLAYS digits saturate to all nines.
module bcd_seq_converter #(
    parameter int INPUT_LENGTH = 8,
    parameter int N_DISPLAYS   = 3,
    parameter int SIGNED_MODE  = 0
) (
    input  logic                clk,
    input  logic                reset,
    bcd_seq_converter_if.slave  bus
);
    localparam int W  = INPUT_LENGTH + 4 * N_DISPLAYS;
    localparam int CW = $clog2(INPUT_LENGTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [W-1:0]            r_sreg;
    logic [CW-1:0]           r_cnt;
    logic                    r_sign;
    logic                    r_ovf_sticky;
    logic                    r_busy;
    logic                    r_done;
    logic [3:0]              r_out [N_DISPLAYS-1:0];
    logic                    r_negative;
    logic                    r_overflow;

    logic [INPUT_LENGTH-1:0] w_mag;
    logic                    w_sign;
    logic [W-1:0]            w_adj;
    logic [W-1:0]            w_shifted;
    logic                    w_top;

    // Magnitude and sign of the incoming value; the most negative input maps
    // to 2^(INPUT_LENGTH-1), which still fits as an unsigned INPUT_LENGTH-bit value.
    always_comb begin
        w_sign = 1'b0;
        w_mag  = bus.binary_in;
        if (SIGNED_MODE != 0 && bus.binary_in[INPUT_LENGTH-1]) begin
            w_sign = 1'b1;
            w_mag  = (~bus.binary_in) + {{(INPUT_LENGTH-1){1'b0}}, 1'b1};
        end
    end

    // Per-digit add-3 correction; each nibble is adjusted on its own, no carries between digits.
    always_comb begin
        w_adj = r_sreg;
        for (int i = 0; i < N_DISPLAYS; i++) begin
            if (r_sreg[INPUT_LENGTH + 4*i +: 4] >= 4'd5) begin
                w_adj[INPUT_LENGTH + 4*i +: 4] = r_sreg[INPUT_LENGTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    // A 1 leaving the top digit means the value needs more digits than we have.
    assign w_top     = w_adj[W-1];
    assign w_shifted = {w_adj[W-2:0], 1'b0};

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sreg       <= '0;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_negative   <= 1'b0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < N_DISPLAYS; i++) begin
                r_out[i] <= 4'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sreg       <= {{(4*N_DISPLAYS){1'b0}}, w_mag};
                        r_sign       <= w_sign;
                        r_ovf_sticky <= 1'b0;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sreg <= w_shifted;
                    if (w_top) begin
                        r_ovf_sticky <= 1'b1;
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(INPUT_LENGTH - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < N_DISPLAYS; i++) begin
                        r_out[i] <= r_ovf_sticky ? 4'd9 : r_sreg[INPUT_LENGTH + 4*i +: 4];
                    end
                    r_overflow <= r_ovf_sticky;
                    r_negative <= r_sign;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.out      = r_out;
    assign bus.negative = r_negative;
    assign bus.overflow = r_overflow;
endmodule
